// File: rtl/core_run_ctrl_pkg.sv
// Shared definitions for the core run controller: state encodings and the default halt encoding.
// Optional breakpoint support (RUN_CTRL_BKPT_EN) uses RC_BREAK from here.
package core_run_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] RC_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] RC_RESET_HOLD = 3'd1;
    localparam logic [STATE_W-1:0] RC_RUN        = 3'd2;
    localparam logic [STATE_W-1:0] RC_DONE       = 3'd3;
    localparam logic [STATE_W-1:0] RC_TIMEOUT    = 3'd4;
    localparam logic [STATE_W-1:0] RC_BREAK      = 3'd5;

    // ECALL is the SYSTEM opcode with every other field zero.
    localparam logic [6:0]  OP_SYSTEM   = 7'h73;
    localparam logic [31:0] ECALL_INSTR = {25'h0, OP_SYSTEM};

endpackage

// File: rtl/core_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the run-cycle and retire counts.
// Part of core_run_ctrl (optional feature macro RUN_CTRL_BKPT_EN does not affect this file).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: holds the datapath in reset, runs it until ECALL or a cycle budget, reports counts.
// Define RUN_CTRL_BKPT_EN to add breakpoint ports (bp_valid, bp_pc, resume) and the BREAK state.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          CNT_W      = 16,
    parameter int          RST_CYCLES = 1,
    parameter int          MAX_CYCLES = 10,
    parameter logic [31:0] HALT_INSTR = ECALL_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      instr_i,
    input  logic             retire_i,
`ifdef RUN_CTRL_BKPT_EN
    input  logic             bp_valid,
    input  logic [XLEN-1:0]  bp_pc,
    input  logic             resume,
`endif
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [XLEN-1:0]  last_pc
);

    localparam int                HOLD_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [XLEN-1:0]    last_pc_q, last_pc_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               running_q, running_d;
    logic               core_reset_q, core_reset_d;
    logic               cyc_clr, cyc_inc, ret_clr, ret_inc;
    logic               halt_hit, budget_hit;

    assign halt_hit   = retire_i && (instr_i == HALT_INSTR);
    assign budget_hit = (cycle_cnt == BUDGET_LAST);

`ifdef RUN_CTRL_BKPT_EN
    // skip_q suppresses an immediate re-fire on the breakpoint pc right after resume.
    logic skip_q, skip_d;
    logic bp_hit;
    assign bp_hit = retire_i && bp_valid && (pc_i == bp_pc) && !skip_q;
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_pc_d = last_pc_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        cyc_clr   = 1'b0;
        cyc_inc   = 1'b0;
        ret_clr   = 1'b0;
        ret_inc   = 1'b0;
`ifdef RUN_CTRL_BKPT_EN
        skip_d    = skip_q;
`endif
        case (state_q)
            RC_IDLE, RC_DONE, RC_TIMEOUT: begin
                if (start && !abort) begin
                    state_d   = RC_RESET_HOLD;
                    hold_d    = '0;
                    cyc_clr   = 1'b1;
                    ret_clr   = 1'b1;
                    last_pc_d = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
`ifdef RUN_CTRL_BKPT_EN
                    skip_d    = 1'b0;
`endif
                end
            end
            RC_RESET_HOLD: begin
                if (abort) begin
                    state_d = RC_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RC_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RC_RUN: begin
                // Abort freezes everything, including this cycle's counts.
                if (abort) begin
                    state_d = RC_IDLE;
                end else begin
                    cyc_inc = 1'b1;
                    if (retire_i) begin
                        ret_inc   = 1'b1;
                        last_pc_d = pc_i;
                    end
                    if (halt_hit) begin
                        state_d = RC_DONE;
                        done_d  = 1'b1;
                    end else if (budget_hit) begin
                        state_d   = RC_TIMEOUT;
                        timeout_d = 1'b1;
`ifdef RUN_CTRL_BKPT_EN
                    end else if (bp_hit) begin
                        state_d = RC_BREAK;
                        skip_d  = 1'b1;
                    end else if (retire_i && (pc_i != bp_pc)) begin
                        skip_d = 1'b0;
`endif
                    end
                end
            end
`ifdef RUN_CTRL_BKPT_EN
            RC_BREAK: begin
                if (abort) begin
                    state_d = RC_IDLE;
                end else if (resume) begin
                    state_d = RC_RUN;
                end
            end
`endif
            default: begin
                state_d = RC_IDLE;
            end
        endcase
    end

    always_comb begin
        running_d    = (state_d == RC_RUN);
        core_reset_d = !running_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RC_IDLE;
            hold_q       <= '0;
            last_pc_q    <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            running_q    <= 1'b0;
            core_reset_q <= 1'b1;
`ifdef RUN_CTRL_BKPT_EN
            skip_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_pc_q    <= last_pc_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            running_q    <= running_d;
            core_reset_q <= core_reset_d;
`ifdef RUN_CTRL_BKPT_EN
            skip_q       <= skip_d;
`endif
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cyc_clr),
        .inc   (cyc_inc),
        .q     (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ret_clr),
        .inc   (ret_inc),
        .q     (retire_cnt)
    );

    assign core_reset = core_reset_q;
    assign running    = running_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign last_pc    = last_pc_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl (default build, RUN_CTRL_BKPT_EN undefined): reference model plus directed vectors.
// A second small-counter instance and a bare sat_counter cover saturation and clear-on-start.
module tb_core_run_ctrl;

    localparam int          RST_A = 3;
    localparam int          MAX_A = 10;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0, abort_a = 1'b0, retire_a = 1'b0;
    logic [31:0] pc_a = '0, instr_a = '0;
    logic        core_reset_a, running_a, done_a, timeout_a;
    logic [15:0] cycle_cnt_a, retire_cnt_a;
    logic [31:0] last_pc_a;

    logic        start_b = 1'b0, abort_b = 1'b0, retire_b = 1'b0;
    logic [31:0] pc_b = '0, instr_b = NOP;
    logic        core_reset_b, running_b, done_b, timeout_b;
    logic [3:0]  cycle_cnt_b, retire_cnt_b;
    logic [31:0] last_pc_b;

    logic        sc_clr = 1'b0, sc_inc = 1'b0;
    logic [3:0]  sc_q;

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    core_run_ctrl #(.XLEN(32), .CNT_W(16), .RST_CYCLES(RST_A), .MAX_CYCLES(MAX_A)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .abort(abort_a),
        .pc_i(pc_a), .instr_i(instr_a), .retire_i(retire_a),
        .core_reset(core_reset_a), .running(running_a), .done(done_a), .timeout(timeout_a),
        .cycle_cnt(cycle_cnt_a), .retire_cnt(retire_cnt_a), .last_pc(last_pc_a)
    );

    core_run_ctrl #(.XLEN(32), .CNT_W(4), .RST_CYCLES(1), .MAX_CYCLES(15)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .abort(abort_b),
        .pc_i(pc_b), .instr_i(instr_b), .retire_i(retire_b),
        .core_reset(core_reset_b), .running(running_b), .done(done_b), .timeout(timeout_b),
        .cycle_cnt(cycle_cnt_b), .retire_cnt(retire_cnt_b), .last_pc(last_pc_b)
    );

    sat_counter #(.W(4)) u_sc (
        .clk(clk), .reset(rst), .clr(sc_clr), .inc(sc_inc), .q(sc_q)
    );

    // Reference model of dut_a: a countdown of hold cycles, a run flag and plain counters.
    int          m_hold_left = 0;
    bit          m_run = 0, m_done = 0, m_to = 0;
    int          m_cyc = 0, m_ret = 0;
    logic [31:0] m_lpc = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_hold_left <= 0; m_run <= 0; m_done <= 0; m_to <= 0;
            m_cyc <= 0; m_ret <= 0; m_lpc <= '0;
        end else if (m_hold_left > 0) begin
            if (abort_a) begin
                m_hold_left <= 0;
            end else begin
                m_hold_left <= m_hold_left - 1;
                if (m_hold_left == 1) m_run <= 1;
            end
        end else if (m_run) begin
            if (abort_a) begin
                m_run <= 0;
            end else begin
                m_cyc <= m_cyc + 1;
                if (retire_a) begin
                    m_ret <= (m_ret >= 65535) ? 65535 : m_ret + 1;
                    m_lpc <= pc_a;
                end
                if (retire_a && instr_a == ECALL) begin
                    m_run <= 0; m_done <= 1;
                end else if (m_cyc + 1 == MAX_A) begin
                    m_run <= 0; m_to <= 1;
                end
            end
        end else if (start_a && !abort_a) begin
            m_hold_left <= RST_A;
            m_done <= 0; m_to <= 0; m_cyc <= 0; m_ret <= 0; m_lpc <= '0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle after reset, dut_a must agree with the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("core_reset", 32'(core_reset_a), 32'(!m_run));
            checkOutput("running",    32'(running_a),    32'(m_run));
            checkOutput("done",       32'(done_a),       32'(m_done));
            checkOutput("timeout",    32'(timeout_a),    32'(m_to));
            checkOutput("cycle_cnt",  32'(cycle_cnt_a),  32'(m_cyc));
            checkOutput("retire_cnt", 32'(retire_cnt_a), 32'(m_ret));
            checkOutput("last_pc",    last_pc_a,         m_lpc);
        end
    end

    task automatic applyStimulus(input logic st, input logic ab, input logic rt,
                                 input logic [31:0] pc, input logic [31:0] ins);
        start_a  = st;
        abort_a  = ab;
        retire_a = rt;
        pc_a     = pc;
        instr_a  = ins;
        @(negedge clk);
        start_a  = 1'b0;
        abort_a  = 1'b0;
        retire_a = 1'b0;
    endtask

    task automatic goRunA();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, NOP);
        for (int i = 0; i < 10; i++) begin
            if (running_a) break;
            applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        end
        checkOutput("wait_run_a", 32'(running_a), 32'd1);
    endtask

    initial begin
        $display("[TB] core_run_ctrl bench start");
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        checkOutput("rst_core_reset", 32'(core_reset_a), 32'd1);
        checkOutput("rst_running",    32'(running_a),    32'd0);
        checkOutput("rst_cycle_cnt",  32'(cycle_cnt_a),  32'd0);
        rst = 1'b0;

        // Start: three hold cycles, running on the fourth edge.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, NOP);
        checkOutput("hold1_core_reset", 32'(core_reset_a), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        checkOutput("hold3_running", 32'(running_a), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        checkOutput("run_running",    32'(running_a),    32'd1);
        checkOutput("run_core_reset", 32'(core_reset_a), 32'd0);

        // Four retires then ECALL at 0x10.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'(i * 4), NOP);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, ECALL);
        checkOutput("halt_done",       32'(done_a),       32'd1);
        checkOutput("halt_retire_cnt", 32'(retire_cnt_a), 32'd5);
        checkOutput("halt_last_pc",    last_pc_a,         32'h10);
        checkOutput("halt_core_reset", 32'(core_reset_a), 32'd1);
        checkOutput("halt_cycle_cnt",  32'(cycle_cnt_a),  32'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, NOP);
        checkOutput("done_ignores_retire", 32'(retire_cnt_a), 32'd5);

        // Budget timeout from DONE; start clears counters.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, NOP);
        checkOutput("restart_cycle_cnt",  32'(cycle_cnt_a),  32'd0);
        checkOutput("restart_retire_cnt", 32'(retire_cnt_a), 32'd0);
        checkOutput("restart_done",       32'(done_a),       32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, (i == 2 || i == 5), 32'(32'h20 + i), NOP);
        checkOutput("pre_budget_timeout", 32'(timeout_a), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        checkOutput("budget_timeout",   32'(timeout_a),    32'd1);
        checkOutput("budget_cycle_cnt", 32'(cycle_cnt_a),  32'd10);
        checkOutput("budget_done",      32'(done_a),       32'd0);
        checkOutput("budget_last_pc",   last_pc_a,         32'h25);

        // ECALL on the budget cycle: halt wins.
        goRunA();
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, ECALL);
        checkOutput("tie_done",      32'(done_a),      32'd1);
        checkOutput("tie_timeout",   32'(timeout_a),   32'd0);
        checkOutput("tie_cycle_cnt", 32'(cycle_cnt_a), 32'd10);

        // Abort in hold, start+abort in IDLE, abort over halt in RUN.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, NOP);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, NOP);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, NOP);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, NOP);
        checkOutput("abort_idle_running", 32'(running_a), 32'd0);
        goRunA();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, NOP);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h104, NOP);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h108, ECALL);
        checkOutput("abort_done",       32'(done_a),       32'd0);
        checkOutput("abort_cycle_cnt",  32'(cycle_cnt_a),  32'd2);
        checkOutput("abort_last_pc",    last_pc_a,         32'h104);
        checkOutput("abort_running",    32'(running_a),    32'd0);

        // Reset mid-run with start high.
        goRunA();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'(32'h200 + 4 * i), NOP);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, ECALL);
        rst = 1'b0;
        checkOutput("midrst_core_reset", 32'(core_reset_a), 32'd1);
        checkOutput("midrst_running",    32'(running_a),    32'd0);
        checkOutput("midrst_retire_cnt", 32'(retire_cnt_a), 32'd0);
        checkOutput("midrst_last_pc",    last_pc_a,         32'h0);

        // Small-counter instance: retire every RUN cycle, then extra retires while stopped.
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 5; i++) if (!running_b) @(negedge clk);
        checkOutput("b_running", 32'(running_b), 32'd1);
        for (int i = 0; i < 20; i++) begin
            retire_b = 1'b1;
            pc_b     = 32'(i * 4);
            @(negedge clk);
        end
        retire_b = 1'b0;
        checkOutput("b_timeout",    32'(timeout_b),    32'd1);
        checkOutput("b_retire_cnt", 32'(retire_cnt_b), 32'd15);
        checkOutput("b_cycle_cnt",  32'(cycle_cnt_b),  32'd15);
        checkOutput("b_last_pc",    last_pc_b,         32'h38);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        checkOutput("b_clr_cycle",   32'(cycle_cnt_b),  32'd0);
        checkOutput("b_clr_retire",  32'(retire_cnt_b), 32'd0);
        checkOutput("b_clr_timeout", 32'(timeout_b),    32'd0);

        // Bare 4-bit counter: 20 increments saturate at 15, clear returns to 0.
        sc_inc = 1'b1;
        for (int i = 0; i < 20; i++) @(negedge clk);
        sc_inc = 1'b0;
        checkOutput("sc_saturate", 32'(sc_q), 32'd15);
        sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0;
        checkOutput("sc_clear", 32'(sc_q), 32'd0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
